// File: rtl/or1k_wb_mem_arbiter.sv
// Round-robin Wishbone B3 arbiter sharing one memory slave among NUM_MASTERS masters.
// Define OR1K_WB_ARB_WATCHDOG_EN to abort cycles the slave never answers within TIMEOUT cycles.
module or1k_wb_mem_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 1024,
  localparam int SW         = DW / 8
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SW-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [NUM_MASTERS-1:0]    m_rty_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [SW-1:0]             s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      busy_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef OR1K_WB_ARB_WATCHDOG_EN
  localparam logic [1:0] ABORT = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);
`endif

  if (NUM_MASTERS < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("or1k_wb_mem_arbiter: NUM_MASTERS and TIMEOUT must both be >= 2");
  end

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          pick_idle, pick_hand, sel_idx;
  logic                   in_grant;

  // First requester above 'last', wrapping; descending scan lets the nearest one win.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IW-1:0] last);
    logic [IW-1:0] idx;
    rr_pick = last;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      idx = IW'((int'(last) + i) % NUM_MASTERS);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign pick_idle = rr_pick(m_cyc_i, last_q);
  assign pick_hand = rr_pick(m_cyc_i, gidx_q);
  assign in_grant  = (state_q == GRANT);
  assign sel_idx   = in_grant ? gidx_q : '0;

  assign s_adr_o = m_adr_i[sel_idx*AW +: AW];
  assign s_dat_o = m_dat_i[sel_idx*DW +: DW];
  assign s_sel_o = m_sel_i[sel_idx*SW +: SW];
  assign s_cti_o = m_cti_i[sel_idx*3 +: 3];
  assign s_bte_o = m_bte_i[sel_idx*2 +: 2];
  assign s_cyc_o = in_grant & m_cyc_i[gidx_q];
  assign s_stb_o = in_grant & m_stb_i[gidx_q];
  assign s_we_o  = in_grant & m_we_i[gidx_q];

  assign m_dat_o = s_dat_i;
  assign m_ack_o = grant_q & {NUM_MASTERS{in_grant & s_ack_i}};
  assign m_rty_o = grant_q & {NUM_MASTERS{in_grant & s_rty_i}};
`ifdef OR1K_WB_ARB_WATCHDOG_EN
  assign m_err_o = grant_q & {NUM_MASTERS{(in_grant & s_err_i) | (state_q == ABORT)}};
`else
  assign m_err_o = grant_q & {NUM_MASTERS{in_grant & s_err_i}};
`endif

  assign grant_o = grant_q;
  assign busy_o  = |grant_q;

`ifdef OR1K_WB_ARB_WATCHDOG_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stalled;

  assign stalled = s_stb_o & ~(s_ack_i | s_err_i | s_rty_i);
  assign cnt_d   = (in_grant && m_cyc_i[gidx_q] && stalled) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d            = GRANT;
          gidx_d             = pick_idle;
          grant_d            = '0;
          grant_d[pick_idle] = 1'b1;
        end
      end
      GRANT: begin
        if (!m_cyc_i[gidx_q]) begin
          last_d = gidx_q;
          if (|m_cyc_i) begin
            gidx_d             = pick_hand;
            grant_d            = '0;
            grant_d[pick_hand] = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
`ifdef OR1K_WB_ARB_WATCHDOG_EN
        else if (cnt_d == CW'(TIMEOUT)) begin
          state_d = ABORT;
        end
`endif
      end
`ifdef OR1K_WB_ARB_WATCHDOG_EN
      ABORT: begin
        state_d = IDLE;
        grant_d = '0;
        last_d  = gidx_q;
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
    end
  end

endmodule
